multicycle_fsm: RTL and testbench
=================================

MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of wait cycles on a memory access before an error is flagged.
REQ-002 SHALL have port clk  in  1  sole clock; every state update occurs on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port inst  in  6  opcode field of the instruction register.
REQ-005 SHALL have port func  in  6  function field of the instruction register.
REQ-006 SHALL have port zero  in  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  in  1  memory completes the current access this cycle.
REQ-008 SHALL have outputs pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write_en, reg_write, alu_src_a, each 1 bit.
REQ-009 SHALL have outputs reg_dst[1:0] (0 rt, 1 rd, 2 $31), mem_to_reg[1:0] (0 ALU, 1 mem, 2 PC), alu_src_b[1:0] (0 reg, 1 const 4, 2 sign-extended imm, 3 shifted imm), alu_op[1:0] (0 add, 1 sub, 2 funct, 3 imm-op), pc_source[1:0] (0 ALU, 1 ALUOut, 2 jump target, 3 rs).
REQ-010 SHALL have outputs state[3:0] (current state, for debug), illegal (1-cycle pulse) and mem_err (1-cycle pulse).

Function
REQ-011 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP and JAL; memory-ready gating is the only Mealy term.
REQ-012 FETCH SHALL hold mem_read=1, iord=0, alu_src_b=1 and alu_op=0 until mem_ready=1; in that cycle it SHALL assert ir_write=1, pc_write=1 and pc_source=0, then go to DECODE.
REQ-013 DECODE SHALL drive alu_src_b=3 and alu_op=0 (branch target), then select the next state by inst: 000000 to EXEC_R; 100011 or 101011 to MEMADR; 001000, 001100, 001101, 001110 or 001010 to EXEC_I; 000100 or 000101 to BRANCH; 000010 to JUMP; 000011 to JAL.
REQ-014 DECODE SHALL, for any other opcode, pulse illegal=1 and return to FETCH.
REQ-015 MEMADR SHALL drive alu_src_a=1, alu_src_b=2 and alu_op=0, then go to MEMRD for lw or MEMWR for sw.
REQ-016 MEMRD SHALL hold mem_read=1 and iord=1 until mem_ready=1, then go to MEMWB.
REQ-017 MEMWB SHALL assert reg_write=1, reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-018 MEMWR SHALL hold mem_write_en=1 and iord=1 until mem_ready=1, then go to FETCH.
REQ-019 EXEC_R SHALL drive alu_src_a=1, alu_src_b=0 and alu_op=2.
REQ-020 EXEC_R with func=001000 (jr) SHALL assert pc_write=1 and pc_source=3, then go to FETCH without register writeback; any other func SHALL go to RWB.
REQ-021 RWB SHALL assert reg_write=1, reg_dst=1 and mem_to_reg=0.
REQ-022 EXEC_I SHALL drive alu_src_a=1, alu_src_b=2 and alu_op=3 (the ALU decodes inst), then go to IWB.
REQ-023 IWB SHALL assert reg_write=1, reg_dst=0 and mem_to_reg=0.
REQ-024 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1 and pc_write_cond=1; the PC SHALL load when zero equals (inst==000100).
REQ-025 JUMP SHALL assert pc_write=1 and pc_source=2.
REQ-026 JAL SHALL do the same as JUMP and additionally assert reg_write=1, reg_dst=2 and mem_to_reg=2.
REQ-027 RWB, IWB, BRANCH, JUMP and JAL SHALL each go to FETCH.
REQ-028 Latencies with mem_ready tied high SHALL be: lw 5 cycles; R-type, I-ALU and sw 4; jr, beq, bne, j and jal 3.
REQ-029 A 4-bit wait counter SHALL count cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0, and SHALL clear on state exit.
REQ-030 When the wait counter reaches MEM_TIMEOUT, the FSM SHALL pulse mem_err, drop the access and go to FETCH without pc_write, ir_write or reg_write.
REQ-031 Every output not listed for a state SHALL be 0.
REQ-032 At most one of pc_write and pc_write_cond SHALL be high in any cycle.

Reset
REQ-033 While rst_n=0, the FSM SHALL be in FETCH, the wait counter SHALL be 0, and all outputs except the FETCH Moore defaults SHALL be 0; ir_write and pc_write SHALL be gated low.
REQ-034 Reset asserted mid-access SHALL abort the access immediately, with no write strobe issued after the edge.
REQ-035 After rst_n deasserts, fetch SHALL start on the first rising clk edge.

Structure
REQ-036 State encodings, opcode/func constants and the select-code constants for alu_op, alu_src_b, pc_source, reg_dst and mem_to_reg SHALL live in a shared package, mips_pkg.
REQ-037 The wait counter SHALL be a sub-module, mem_wait_timer (inputs clk, rst_n, busy; output timeout).

Verification
REQ-038 Bench SHALL run lw (100011) with mem_ready high -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 in cycle 5 only.
REQ-039 Bench SHALL run beq with zero=1, then with zero=0 -> pc_write_cond=1 in cycle 3 both times; return to FETCH at cycle 4.
REQ-040 Bench SHALL run an R-type with func=001000 -> pc_write=1 and pc_source=3 in cycle 3; reg_write is never asserted.
REQ-041 Bench SHALL issue sw with mem_ready low for 3 cycles in MEMWR -> mem_write_en high 4 cycles; FETCH follows.
REQ-042 Bench SHALL issue opcode 111111 -> illegal pulses in the DECODE cycle; FETCH next with no writes; then hold mem_ready=0 in FETCH for 15 cycles -> mem_err pulses and ir_write stays 0.
REQ-043 Bench SHALL drop rst_n during MEMRD wait -> state=FETCH asynchronously and mem_read returns to the FETCH value.

Source files
------------

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared constants for the multicycle MIPS control FSM: state encodings,
// opcode/function codes and datapath select codes.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  // FSM state encodings (4-bit, also exported on the debug state port)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_EXEC_I = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Function field values
  localparam logic [5:0] FN_JR    = 6'b001000;

  // alu_op select codes
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_IMM   = 2'd3;

  // alu_src_b select codes
  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_SHIMM = 2'd3;

  // pc_source select codes
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  // reg_dst select codes
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // mem_to_reg select codes
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  // True for the immediate-ALU opcodes handled by EXEC_I
  function automatic logic is_i_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_XORI) || (op == OP_SLTI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles of a stalled memory access and flags a timeout
// on the MEM_TIMEOUT-th stalled cycle.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  output logic timeout
);

  logic [3:0] count;

  // count holds the number of earlier stalled cycles, so the current cycle
  // is the MEM_TIMEOUT-th one when count reaches MEM_TIMEOUT-1
  assign timeout = rst_n && busy && (count == 4'(MEM_TIMEOUT - 1));

  // Stall counter: clears whenever the access completes, leaves its state,
  // or is abandoned on timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (!busy || timeout) begin
      count <= 4'd0;
    end else begin
      count <= count + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_fsm
// Control unit for a multicycle MIPS datapath: Moore FSM with memory-ready
// gating, illegal-opcode detection and memory-access timeout.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_fsm
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] inst,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write_en,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal,
  output logic       mem_err
);

  logic [3:0] next_state;
  logic       mem_state;
  logic       busy;
  logic       timeout;
  logic       decode_legal;

  // The branch condition on zero is resolved by the datapath's PC enable
  // (pc_write_cond qualified by zero and the opcode), not by this FSM
  logic       unused_zero;
  assign unused_zero = zero;

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign busy      = mem_state && !mem_ready;

  assign decode_legal = (inst == OP_RTYPE) || (inst == OP_LW) || (inst == OP_SW) ||
                        is_i_alu(inst) || (inst == OP_BEQ) || (inst == OP_BNE) ||
                        (inst == OP_J) || (inst == OP_JAL);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy   (busy),
    .timeout(timeout)
  );

  // State register; reset forces FETCH immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = (mem_ready && !timeout) ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (inst == OP_RTYPE)                      next_state = S_EXEC_R;
        else if (inst == OP_LW || inst == OP_SW)   next_state = S_MEMADR;
        else if (is_i_alu(inst))                   next_state = S_EXEC_I;
        else if (inst == OP_BEQ || inst == OP_BNE) next_state = S_BRANCH;
        else if (inst == OP_J)                     next_state = S_JUMP;
        else if (inst == OP_JAL)                   next_state = S_JAL;
        else                                       next_state = S_FETCH;
      end
      S_MEMADR: next_state = (inst == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = timeout ? S_FETCH : (mem_ready ? S_MEMWB : S_MEMRD);
      S_MEMWR:  next_state = (timeout || mem_ready) ? S_FETCH : S_MEMWR;
      S_EXEC_R: next_state = (func == FN_JR) ? S_FETCH : S_RWB;
      S_EXEC_I: next_state = S_IWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // Output decode; memory-ready gating in FETCH is the only Mealy term
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write_en  = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    reg_dst       = REGDST_RT;
    mem_to_reg    = M2R_ALU;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal       = 1'b0;
    mem_err       = timeout;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        pc_source = PCSRC_ALU;
        if (mem_ready && rst_n) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_SHIMM;
        alu_op    = ALU_ADD;
        illegal   = !decode_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_MEM;
      end
      S_MEMWR: begin
        mem_write_en = 1'b1;
        iord         = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALU_FUNCT;
        if (func == FN_JR) begin
          pc_write  = 1'b1;
          pc_source = PCSRC_RS;
        end
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RD;
        mem_to_reg = M2R_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_IMM;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_ALU;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = REGDST_RA;
        mem_to_reg = M2R_PC;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_fsm.sv
// ----------------------------------------------------------------------------
// tb_multicycle_fsm
// Directed self-checking bench for the multicycle control FSM.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] inst;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write_en;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       illegal;
  logic       mem_err;

  int n_checks = 0;
  int n_fails  = 0;

  multicycle_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst         (inst),
    .func         (func),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .ir_write     (ir_write),
    .iord         (iord),
    .mem_read     (mem_read),
    .mem_write_en (mem_write_en),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .state        (state),
    .illegal      (illegal),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample one time unit after the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("pcw_excl", 32'(pc_write & pc_write_cond), 32'd0);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic run_branch(input string tag, input logic z);
    inst = 6'b000100;
    zero = z;
    settle();
    check({tag, "_c1_state"}, 32'(state), 32'd0);
    tick();
    check({tag, "_c2_state"}, 32'(state), 32'd1);
    check({tag, "_c2_pwc"}, 32'(pc_write_cond), 32'd0);
    tick();
    check({tag, "_c3_state"}, 32'(state), 32'd10);
    check({tag, "_c3_pwc"}, 32'(pc_write_cond), 32'd1);
    check({tag, "_c3_pw"}, 32'(pc_write), 32'd0);
    check({tag, "_c3_pcsrc"}, 32'(pc_source), 32'd1);
    check({tag, "_c3_aluop"}, 32'(alu_op), 32'd1);
    tick();
    check({tag, "_c4_state"}, 32'(state), 32'd0);
    check({tag, "_c4_pwc"}, 32'(pc_write_cond), 32'd0);
  endtask

  initial begin
    int cnt;
    rst_n     = 1'b0;
    inst      = 6'b000000;
    func      = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;

    // Reset: FETCH defaults with write strobes gated despite mem_ready=1
    #23;
    check("rst_state", 32'(state), 32'd0);
    check("rst_memrd", 32'(mem_read), 32'd1);
    check("rst_srcb", 32'(alu_src_b), 32'd1);
    check("rst_irw", 32'(ir_write), 32'd0);
    check("rst_pcw", 32'(pc_write), 32'd0);
    check("rst_regw", 32'(reg_write), 32'd0);
    check("rst_memerr", 32'(mem_err), 32'd0);

    // lw with mem_ready high: 5 cycles
    @(negedge clk);
    rst_n = 1'b1;
    inst  = 6'b100011;
    settle();
    check("lw_c1_state", 32'(state), 32'd0);
    check("lw_c1_irw", 32'(ir_write), 32'd1);
    check("lw_c1_pcw", 32'(pc_write), 32'd1);
    check("lw_c1_regw", 32'(reg_write), 32'd0);
    tick();
    check("lw_c2_state", 32'(state), 32'd1);
    check("lw_c2_srcb", 32'(alu_src_b), 32'd3);
    check("lw_c2_regw", 32'(reg_write), 32'd0);
    tick();
    check("lw_c3_state", 32'(state), 32'd2);
    check("lw_c3_srca", 32'(alu_src_a), 32'd1);
    check("lw_c3_srcb", 32'(alu_src_b), 32'd2);
    check("lw_c3_regw", 32'(reg_write), 32'd0);
    tick();
    check("lw_c4_state", 32'(state), 32'd3);
    check("lw_c4_iord", 32'(iord), 32'd1);
    check("lw_c4_memrd", 32'(mem_read), 32'd1);
    check("lw_c4_regw", 32'(reg_write), 32'd0);
    tick();
    check("lw_c5_state", 32'(state), 32'd4);
    check("lw_c5_regw", 32'(reg_write), 32'd1);
    check("lw_c5_m2r", 32'(mem_to_reg), 32'd1);
    check("lw_c5_regdst", 32'(reg_dst), 32'd0);
    tick();
    check("lw_c6_state", 32'(state), 32'd0);
    check("lw_c6_regw", 32'(reg_write), 32'd0);

    // beq taken and not taken: identical control sequence
    run_branch("beq_z1", 1'b1);
    run_branch("beq_z0", 1'b0);

    // jr: PC from rs in EXEC_R, no writeback
    inst = 6'b000000;
    func = 6'b001000;
    settle();
    check("jr_c1_regw", 32'(reg_write), 32'd0);
    tick();
    check("jr_c2_state", 32'(state), 32'd1);
    check("jr_c2_regw", 32'(reg_write), 32'd0);
    tick();
    check("jr_c3_state", 32'(state), 32'd6);
    check("jr_c3_pcw", 32'(pc_write), 32'd1);
    check("jr_c3_pcsrc", 32'(pc_source), 32'd3);
    check("jr_c3_aluop", 32'(alu_op), 32'd2);
    check("jr_c3_regw", 32'(reg_write), 32'd0);
    tick();
    check("jr_c4_state", 32'(state), 32'd0);
    check("jr_c4_regw", 32'(reg_write), 32'd0);

    // sw with three stalled cycles in MEMWR
    inst = 6'b101011;
    func = 6'b000000;
    settle();
    tick();
    check("sw_c2_state", 32'(state), 32'd1);
    tick();
    check("sw_c3_state", 32'(state), 32'd2);
    mem_ready = 1'b0;
    settle();
    tick();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ready = 1'b1;
        settle();
      end
      check("sw_wr_state", 32'(state), 32'd5);
      check("sw_wr_iord", 32'(iord), 32'd1);
      if (mem_write_en) cnt++;
      tick();
    end
    check("sw_we_cycles", 32'(cnt), 32'd4);
    check("sw_after_state", 32'(state), 32'd0);
    check("sw_after_we", 32'(mem_write_en), 32'd0);

    // Illegal opcode, then a FETCH that times out
    inst = 6'b111111;
    settle();
    check("ill_c1_ill", 32'(illegal), 32'd0);
    tick();
    check("ill_c2_state", 32'(state), 32'd1);
    check("ill_c2_ill", 32'(illegal), 32'd1);
    tick();
    mem_ready = 1'b0;
    settle();
    check("ill_c3_state", 32'(state), 32'd0);
    check("ill_c3_ill", 32'(illegal), 32'd0);
    check("ill_c3_regw", 32'(reg_write), 32'd0);
    check("ill_c3_we", 32'(mem_write_en), 32'd0);
    cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      check("to_irw", 32'(ir_write), 32'd0);
      check("to_pcw", 32'(pc_write), 32'd0);
      check("to_state", 32'(state), 32'd0);
      check("to_memerr", 32'(mem_err), 32'(i == 15));
      if (mem_err) cnt++;
      tick();
    end
    check("to_pulses", 32'(cnt), 32'd1);
    check("to_after_memerr", 32'(mem_err), 32'd0);
    check("to_after_state", 32'(state), 32'd0);

    // Reset during a stalled MEMRD
    inst      = 6'b100011;
    mem_ready = 1'b1;
    settle();
    tick();
    tick();
    mem_ready = 1'b0;
    settle();
    tick();
    check("ar_memrd_state", 32'(state), 32'd3);
    tick();
    check("ar_wait_state", 32'(state), 32'd3);
    check("ar_wait_iord", 32'(iord), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_state", 32'(state), 32'd0);
    check("ar_memrd", 32'(mem_read), 32'd1);
    check("ar_iord", 32'(iord), 32'd0);
    check("ar_regw", 32'(reg_write), 32'd0);
    check("ar_we", 32'(mem_write_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    tick();
    check("ar_post_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
